// File: rtl/derm_input_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// derm_input_buffer_pingpong
//
// Double-buffered (ping/pong) soft-bit input buffer for the de-rate-matching
// path. NUM_USER parallel lanes of DATA_W bits, each bank 2^ADDR_W words deep.
// The LLR writer fills bank wr_sel while the de-rate-matching engine reads
// bank rd_sel. A per-bank full flag gives the free/full handshake.
//
// Build option:
//   DERM_IBUF_OUTREG_EN  defined   -> output data register after the RAM,
//                                     read latency 2, o_rd_data resets to 0
//                        undefined -> o_rd_data straight from the RAM output
//                                     register, read latency 1
//
// Ports:
//   i_core_clk   core clock, rising edge
//   i_rx_rstn    asynchronous active-low reset
//   i_wr_en      per-lane write enable (bit k -> lane k)
//   i_wr_addr    common write address
//   i_wr_data    lane k at [k*DATA_W +: DATA_W]
//   i_wr_done    pulse: current write bank complete
//   o_wr_ready   current write bank is free
//   i_rd_en      read request, all lanes together
//   i_rd_addr    common read address
//   i_rd_done    pulse: current read bank consumed
//   o_rd_ready   current read bank is full
//   o_rd_valid   o_rd_data valid this cycle
//   o_rd_data    read data, same lane packing as i_wr_data
//   o_bank_cnt   number of full banks (0..2)
//   o_err        sticky: bit0 write-side misuse, bit1 read-side misuse
// -----------------------------------------------------------------------------
module derm_input_buffer_pingpong #(
  parameter int DATA_W   = 36,
  parameter int ADDR_W   = 11,
  parameter int NUM_USER = 16
) (
  input  logic                         i_core_clk,
  input  logic                         i_rx_rstn,
  input  logic [NUM_USER-1:0]          i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [NUM_USER*DATA_W-1:0]   i_wr_data,
  input  logic                         i_wr_done,
  output logic                         o_wr_ready,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic                         i_rd_done,
  output logic                         o_rd_ready,
  output logic                         o_rd_valid,
  output logic [NUM_USER*DATA_W-1:0]   o_rd_data,
  output logic [1:0]                   o_bank_cnt,
  output logic [1:0]                   o_err
);

  localparam int BANK_WORDS = 1 << ADDR_W;

  logic       r_wr_sel;
  logic       r_rd_sel;
  logic [1:0] r_full;
  logic [1:0] r_err;
  logic       r_rd_vld1;

  logic       w_wr_ready;
  logic       w_rd_ready;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_wr_done_acc;
  logic       w_rd_done_acc;
  logic [1:0] w_full_nxt;
  logic [NUM_USER*DATA_W-1:0] w_ram_q;

  assign w_wr_ready    = ~r_full[r_wr_sel];
  assign w_rd_ready    = r_full[r_rd_sel];
  assign w_wr_acc      = w_wr_ready;
  assign w_rd_acc      = i_rd_en & w_rd_ready;
  assign w_wr_done_acc = i_wr_done & w_wr_ready;
  assign w_rd_done_acc = i_rd_done & w_rd_ready;

  assign o_wr_ready = w_wr_ready;
  assign o_rd_ready = w_rd_ready;
  assign o_bank_cnt = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign o_err      = r_err;

  // A free bank is never also a full bank, so a simultaneous set and clear
  // always land on different bits.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    w_full_nxt = r_full;
    if (w_wr_done_acc) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_done_acc) w_full_nxt[r_rd_sel] = 1'b0;
  end

  // Handshake state, sticky error flags and the first read-valid stage.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_full    <= 2'b00;
      r_err     <= 2'b00;
      r_rd_vld1 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples the pre-edge values regardless of statement order.
      r_full    <= w_full_nxt;
      r_rd_vld1 <= w_rd_acc;
      if (w_wr_done_acc) r_wr_sel <= ~r_wr_sel;
      if (w_rd_done_acc) r_rd_sel <= ~r_rd_sel;
      if ((|i_wr_en || i_wr_done) && !w_wr_ready) r_err[0] <= 1'b1;
      if ((i_rd_en || i_rd_done) && !w_rd_ready)  r_err[1] <= 1'b1;
    end
  end

  // One RAM per lane, both banks stacked: address = {bank, word}.
  // The bank used by a read is the pre-toggle rd_sel, so a read issued with
  // i_rd_done still returns the old bank.
  for (genvar k = 0; k < NUM_USER; k++) begin : g_lane
    logic [DATA_W-1:0] r_mem [0:2*BANK_WORDS-1];
    logic [DATA_W-1:0] r_q;

    // NOTE: the RAM array and its output register carry no reset; contents
    // after reset are stale and are only trusted once rewritten.
    always_ff @(posedge i_core_clk) begin
      if (w_wr_acc && i_wr_en[k]) begin
        r_mem[{r_wr_sel, i_wr_addr}] <= i_wr_data[k*DATA_W +: DATA_W];
      end
      // r_q only moves on an accepted read, which gives the hold behaviour.
      if (w_rd_acc) begin
        r_q <= r_mem[{r_rd_sel, i_rd_addr}];
      end
    end

    assign w_ram_q[k*DATA_W +: DATA_W] = r_q;
  end

`ifdef DERM_IBUF_OUTREG_EN
  logic                       r_rd_vld2;
  logic [NUM_USER*DATA_W-1:0] r_dout;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_rd_vld2 <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_rd_vld2 <= r_rd_vld1;
      if (r_rd_vld1) r_dout <= w_ram_q;
    end
  end

  assign o_rd_valid = r_rd_vld2;
  assign o_rd_data  = r_dout;
`else
  assign o_rd_valid = r_rd_vld1;
  assign o_rd_data  = w_ram_q;
`endif

endmodule

// File: tb/tb_derm_input_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// tb_derm_input_buffer_pingpong
//
// Bench for derm_input_buffer_pingpong at NUM_USER=4, DATA_W=8, ADDR_W=4.
// Build with or without DERM_IBUF_OUTREG_EN; the expected read latency follows.
// A behavioural model (bank arrays, full flags, queue of expected reads with
// their due cycle) predicts every output each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_derm_input_buffer_pingpong;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NU    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int W     = NU * DW;
`ifdef DERM_IBUF_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NU-1:0] wr_en = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_done = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done = 1'b0;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [1:0]    bank_cnt;
  logic [1:0]    err;

  derm_input_buffer_pingpong #(.DATA_W(DW), .ADDR_W(AW), .NUM_USER(NU)) dut (
    .i_core_clk(clk),
    .i_rx_rstn (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_wr_done (wr_done),
    .o_wr_ready(wr_ready),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .i_rd_done (rd_done),
    .o_rd_ready(rd_ready),
    .o_rd_valid(rd_valid),
    .o_rd_data (rd_data),
    .o_bank_cnt(bank_cnt),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rd_exp_t;

  logic [DW-1:0] m_mem [2][DEPTH][NU];
  logic [1:0]    m_full;
  int            m_wr, m_rd;
  logic [1:0]    m_err;
  rd_exp_t       m_q[$];
  logic [W-1:0]  m_last;
  bit            m_last_known;

  int cyc   = 0;
  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int bank, input int k, input int a);
    logic [DW-1:0] v;
    v = DW'(k * DEPTH + a);
    return (bank == 0) ? v : ~v;
  endfunction

  function automatic logic [W-1:0] pat_word(input int bank, input int a);
    logic [W-1:0] w;
    for (int k = 0; k < NU; k++) w[k*DW +: DW] = pat(bank, k, a);
    return w;
  endfunction

  task automatic model_reset();
    m_full = 2'b00;
    m_wr   = 0;
    m_rd   = 0;
    m_err  = 2'b00;
    m_q.delete();
`ifdef DERM_IBUF_OUTREG_EN
    m_last       = '0;
    m_last_known = 1'b1;
`else
    m_last_known = 1'b0;
`endif
  endtask

  // Apply the spec rules for one sampled cycle.
  task automatic model_cycle(input logic [NU-1:0] we, input int wa, input logic [W-1:0] wd,
                             input bit wdone, input bit re, input int ra, input bit rdone);
    bit           wr_ok, rd_ok;
    int           wb, rb;
    logic [W-1:0] d;
    wr_ok = !m_full[wb_sel()];
    rd_ok = m_full[m_rd];
    wb = m_wr;
    rb = m_rd;
    if (we != '0) begin
      if (wr_ok) begin
        for (int k = 0; k < NU; k++) if (we[k]) m_mem[wb][wa][k] = wd[k*DW +: DW];
      end else m_err[0] = 1'b1;
    end
    if (wdone) begin
      if (wr_ok) begin m_full[wb] = 1'b1; m_wr = 1 - wb; end
      else m_err[0] = 1'b1;
    end
    if (re) begin
      if (rd_ok) begin
        for (int k = 0; k < NU; k++) d[k*DW +: DW] = m_mem[rb][ra][k];
        m_q.push_back('{due: cyc + L - 1, data: d});
      end else m_err[1] = 1'b1;
    end
    if (rdone) begin
      if (rd_ok) begin m_full[rb] = 1'b0; m_rd = 1 - rb; end
      else m_err[1] = 1'b1;
    end
  endtask

  function automatic int wb_sel();
    return m_wr;
  endfunction

  task automatic check_outputs();
    check("wr_ready", 64'(wr_ready), 64'(!m_full[m_wr]));
    check("rd_ready", 64'(rd_ready), 64'(m_full[m_rd]));
    check("bank_cnt", 64'(bank_cnt), 64'(m_full[0]) + 64'(m_full[1]));
    check("err",      64'(err),      64'(m_err));
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_data",  64'(rd_data),  64'(m_q[0].data));
      m_last       = m_q[0].data;
      m_last_known = 1'b1;
      void'(m_q.pop_front());
    end else begin
      check("rd_valid_idle", 64'(rd_valid), 64'd0);
      if (m_last_known) check("rd_data_hold", 64'(rd_data), 64'(m_last));
    end
  endtask

  task automatic step(input logic [NU-1:0] we, input int wa, input logic [W-1:0] wd,
                      input bit wdone, input bit re, input int ra, input bit rdone);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    wr_done = wdone;
    rd_en   = re;
    rd_addr = AW'(ra);
    rd_done = rdone;
    @(posedge clk);
    cyc++;
    model_cycle(we, wa, wd, wdone, re, ra, rdone);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step('0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    check({tag, "_rd_ready"}, 64'(rd_ready), 64'd0);
    check({tag, "_bank_cnt"}, 64'(bank_cnt), 64'd0);
    check({tag, "_err"},      64'(err),      64'd0);
`ifdef DERM_IBUF_OUTREG_EN
    check({tag, "_rd_data"},  64'(rd_data),  64'd0);
`endif
  endtask

  // Called right after a step (posedge+1); holds reset for 3 edges.
  task automatic do_reset(input string tag);
    wr_en = '0; wr_done = 0; rd_en = 0; rd_done = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check_reset_outputs(tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  // Handshake-only table applied straight after reset.
  typedef struct {
    logic [NU-1:0] we;
    bit            wdone;
    bit            re;
    bit            rdone;
    bit            e_wr_ready;
    bit            e_rd_ready;
    logic [1:0]    e_cnt;
    logic [1:0]    e_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    // underflow, fill, simultaneous done, both full, overflow, drain
    vt[0] = '{we: 4'h0, wdone: 0, re: 1, rdone: 1, e_wr_ready: 1, e_rd_ready: 0, e_cnt: 2'd0, e_err: 2'b10};
    vt[1] = '{we: 4'h0, wdone: 1, re: 0, rdone: 0, e_wr_ready: 1, e_rd_ready: 1, e_cnt: 2'd1, e_err: 2'b10};
    vt[2] = '{we: 4'h0, wdone: 1, re: 0, rdone: 1, e_wr_ready: 1, e_rd_ready: 1, e_cnt: 2'd1, e_err: 2'b10};
    vt[3] = '{we: 4'h0, wdone: 1, re: 0, rdone: 0, e_wr_ready: 0, e_rd_ready: 1, e_cnt: 2'd2, e_err: 2'b10};
    vt[4] = '{we: 4'h1, wdone: 0, re: 0, rdone: 0, e_wr_ready: 0, e_rd_ready: 1, e_cnt: 2'd2, e_err: 2'b11};
    vt[5] = '{we: 4'h0, wdone: 0, re: 0, rdone: 1, e_wr_ready: 1, e_rd_ready: 1, e_cnt: 2'd1, e_err: 2'b11};
    vt[6] = '{we: 4'h0, wdone: 0, re: 0, rdone: 1, e_wr_ready: 1, e_rd_ready: 0, e_cnt: 2'd0, e_err: 2'b11};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    check_reset_outputs("por");

    for (int i = 0; i < 7; i++) begin
      step(vt[i].we, 0, '0, vt[i].wdone, vt[i].re, 0, vt[i].rdone);
      check($sformatf("tbl%0d_wr_ready", i), 64'(wr_ready), 64'(vt[i].e_wr_ready));
      check($sformatf("tbl%0d_rd_ready", i), 64'(rd_ready), 64'(vt[i].e_rd_ready));
      check($sformatf("tbl%0d_cnt", i),      64'(bank_cnt), 64'(vt[i].e_cnt));
      check($sformatf("tbl%0d_err", i),      64'(err),      64'(vt[i].e_err));
    end
    check("tbl_no_valid", 64'(rd_valid), 64'd0);
    do_reset("rst1");

    // Basic: fill bank 0 on all lanes, then done.
    for (int a = 0; a < DEPTH; a++) step('1, a, pat_word(0, a), 0, 0, 0, 0);
    step('0, 0, '0, 1, 0, 0, 0);
    check("fill0_rd_ready", 64'(rd_ready), 64'd1);
    check("fill0_cnt",      64'(bank_cnt), 64'd1);

    // Concurrency: read bank 0 while filling bank 1.
    for (int a = 0; a < DEPTH; a++) step('1, a, pat_word(1, a), 0, 1, a, 0);
    step('0, 0, '0, 1, 0, 0, 0);
    check("both_full_cnt",      64'(bank_cnt), 64'd2);
    check("both_full_wr_ready", 64'(wr_ready), 64'd0);

    // Overflow: lane-0 write to addr 5 plus wr_done while both banks are full.
    step(4'h1, 5, {W{1'b1}}, 1, 0, 0, 0);
    check("ovf_err", 64'(err),      64'b01);
    check("ovf_cnt", 64'(bank_cnt), 64'd2);

    // Read of addr 7 together with rd_done returns bank-0 word 7.
    step('0, 0, '0, 0, 1, 7, 1);
    check("rddone_cnt", 64'(bank_cnt), 64'd1);
    for (int i = 0; i < L; i++) idle();
    check("old_bank_w7", 64'(rd_data), 64'(pat_word(0, 7)));

    // Bank 1 read-back, including addr 5 left untouched by the overflow.
    for (int a = 0; a < DEPTH; a++) step('0, 0, '0, 0, 1, a, 0);
    for (int i = 0; i < L; i++) idle();

    // wr_done and rd_done together with one full bank.
    step('0, 0, '0, 1, 0, 0, 1);
    check("simul_cnt",      64'(bank_cnt), 64'd1);
    check("simul_rd_ready", 64'(rd_ready), 64'd1);
    check("simul_wr_ready", 64'(wr_ready), 64'd1);

    // Reset with two reads in flight.
    step('0, 0, '0, 0, 1, 3, 0);
    rd_en   = 1'b1;
    rd_addr = AW'(9);
    @(posedge clk);
    cyc++;
    #1;
    do_reset("rst_mid");
    for (int i = 0; i < L + 1; i++) begin
      idle();
      check("post_rst_no_valid", 64'(rd_valid), 64'd0);
    end

    // Randomised traffic; memory is fully written, so every read is defined.
    for (int i = 0; i < 800; i++) begin
      logic [NU-1:0] we;
      logic [W-1:0]  wd;
      we = ($urandom_range(0, 3) == 0) ? '0 : NU'($urandom);
      wd = W'($urandom);
      step(we, int'($urandom_range(0, DEPTH - 1)), wd,
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 11) == 0));
    end
    for (int i = 0; i < L + 1; i++) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
